// File: rtl/clap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clap_pkg
//  Description : Shared state encoding and command-count constants for the
//                clap command controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package clap_pkg;

    // Controller states (3-bit encoding)
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LISTEN  = 3'd1,
        HIT     = 3'd2,
        LOCKOUT = 3'd3,
        GAP     = 3'd4,
        REPORT  = 3'd5
    } clap_state_e;

    // Clap counts that select an appliance
    localparam logic [1:0] CMD_LIGHT = 2'd2;
    localparam logic [1:0] CMD_FAN   = 2'd3;

endpackage : clap_pkg
`default_nettype wire

// File: rtl/clap_window_timer.sv
`default_nettype none
// ============================================================================
//  Module      : clap_window_timer
//  Description : Saturating up-counter measuring time since the last clap,
//                with lockout-end and window-end compare flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module clap_window_timer #(
    parameter int CNT_W       = 16,
    parameter int LOCKOUT_CYC = 1000,
    parameter int WINDOW_CYC  = 50000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic run,
    output logic lockout_done,
    output logic window_done
);

    localparam logic [CNT_W-1:0] C_LOCK_LAST = CNT_W'(LOCKOUT_CYC - 1);
    localparam logic [CNT_W-1:0] C_WIN_LAST  = CNT_W'(WINDOW_CYC - 1);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise count up and hold at all-ones
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (run && (count_q != '1)) begin
            count_d = count_q + C_ONE;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign lockout_done = (count_q == C_LOCK_LAST);
    assign window_done  = (count_q == C_WIN_LAST);

endmodule : clap_window_timer
`default_nettype wire

// File: rtl/clap_command_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clap_command_ctrl
//  Description : Qualifies loud samples into claps, groups claps into
//                commands within a time window, and toggles light / fan.
//  Revision    : 1.0 - initial release
// ============================================================================
module clap_command_ctrl
    import clap_pkg::*;
#(
    parameter int                  SAMPLE_W    = 8,
    parameter logic [SAMPLE_W-1:0] THRESHOLD   = 8'h10,
    parameter int                  HIT_SAMPLES = 2,
    parameter int                  LOCKOUT_CYC = 1000,
    parameter int                  WINDOW_CYC  = 50000,
    parameter int                  MAX_CLAPS   = 3,
    parameter int                  CNT_W       = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] audio_in,
    output logic                clap_pulse,
    output logic                cmd_valid,
    output logic [1:0]          cmd_claps,
    output logic                light_on,
    output logic                fan_on,
    output logic                busy
);

    localparam logic [2:0] C_HIT_LAST  = 3'(HIT_SAMPLES);
    localparam logic [1:0] C_MAX_CLAPS = 2'(MAX_CLAPS);

    clap_state_e state_q, state_d;
    logic [2:0]  hit_cnt_q, hit_cnt_d;
    logic [1:0]  clap_cnt_q, clap_cnt_d;
    logic        clap_pulse_q, clap_pulse_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [1:0]  cmd_claps_q, cmd_claps_d;
    logic        light_on_q, light_on_d;
    logic        fan_on_q, fan_on_d;
    logic        busy_q, busy_d;

    logic loud_hit;
    logic clap_reg;
    logic cmd_fire;
    logic in_seq;
    logic window_exp;
    logic lockout_done;
    logic window_done;

    assign loud_hit   = sample_valid && (audio_in > THRESHOLD);
    // Timer only measures while a sequence is open and we are between claps
    assign in_seq     = enable && (clap_cnt_q != 2'd0) &&
                        ((state_q == LOCKOUT) || (state_q == GAP) || (state_q == HIT));
    assign window_exp = window_done && (clap_cnt_q != 2'd0);

    clap_window_timer #(
        .CNT_W       (CNT_W),
        .LOCKOUT_CYC (LOCKOUT_CYC),
        .WINDOW_CYC  (WINDOW_CYC)
    ) u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .clr          (clap_reg || !in_seq),
        .run          (in_seq),
        .lockout_done (lockout_done),
        .window_done  (window_done)
    );

    // Sequencer: hit qualification, lockout, window grouping and reporting
    always_comb begin
        state_d    = state_q;
        hit_cnt_d  = hit_cnt_q;
        clap_cnt_d = clap_cnt_q;
        clap_reg   = 1'b0;
        cmd_fire   = 1'b0;
        if (!enable) begin
            state_d    = IDLE;
            hit_cnt_d  = 3'd0;
            clap_cnt_d = 2'd0;
        end else begin
            case (state_q)
                IDLE: state_d = LISTEN;
                LISTEN, GAP: begin
                    // Window expiry beats a simultaneous loud sample
                    if ((state_q == GAP) && window_exp) begin
                        state_d = REPORT;
                    end else if (loud_hit) begin
                        if (C_HIT_LAST == 3'd1) begin
                            clap_reg = 1'b1;
                        end else begin
                            hit_cnt_d = 3'd1;
                            state_d   = HIT;
                        end
                    end
                end
                HIT: begin
                    if (window_exp) begin
                        hit_cnt_d = 3'd0;
                        state_d   = REPORT;
                    end else if (sample_valid) begin
                        if (loud_hit) begin
                            if ((hit_cnt_q + 3'd1) == C_HIT_LAST) begin
                                clap_reg = 1'b1;
                            end else begin
                                hit_cnt_d = hit_cnt_q + 3'd1;
                            end
                        end else begin
                            hit_cnt_d = 3'd0;
                            state_d   = (clap_cnt_q == 2'd0) ? LISTEN : GAP;
                        end
                    end
                end
                LOCKOUT: begin
                    if (lockout_done) begin
                        state_d = GAP;
                    end
                end
                REPORT: begin
                    cmd_fire   = 1'b1;
                    clap_cnt_d = 2'd0;
                    state_d    = LISTEN;
                end
                default: state_d = IDLE;
            endcase

            if (clap_reg) begin
                hit_cnt_d  = 3'd0;
                clap_cnt_d = clap_cnt_q + 2'd1;
                state_d    = ((clap_cnt_q + 2'd1) == C_MAX_CLAPS) ? REPORT : LOCKOUT;
            end
        end
    end

    // Output and appliance next-state values
    always_comb begin
        clap_pulse_d = clap_reg;
        cmd_valid_d  = cmd_fire;
        cmd_claps_d  = cmd_fire ? clap_cnt_q : cmd_claps_q;
        light_on_d   = light_on_q ^ (cmd_fire && (clap_cnt_q == CMD_LIGHT));
        fan_on_d     = fan_on_q   ^ (cmd_fire && (clap_cnt_q == CMD_FAN));
        busy_d       = (state_d != IDLE) && (state_d != LISTEN);
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            hit_cnt_q    <= 3'd0;
            clap_cnt_q   <= 2'd0;
            clap_pulse_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_claps_q  <= 2'd0;
            light_on_q   <= 1'b0;
            fan_on_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hit_cnt_q    <= hit_cnt_d;
            clap_cnt_q   <= clap_cnt_d;
            clap_pulse_q <= clap_pulse_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_claps_q  <= cmd_claps_d;
            light_on_q   <= light_on_d;
            fan_on_q     <= fan_on_d;
            busy_q       <= busy_d;
        end
    end

    assign clap_pulse = clap_pulse_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_claps  = cmd_claps_q;
    assign light_on   = light_on_q;
    assign fan_on     = fan_on_q;
    assign busy       = busy_q;

endmodule : clap_command_ctrl
`default_nettype wire

// File: tb/tb_clap_command_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clap_command_ctrl
//  Description : Directed and random stimulus against a time-based model of
//                clap qualification, lockout, windowing and commands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clap_command_ctrl;

    localparam int         HITS = 2;
    localparam int         LOCK = 4;
    localparam int         WIN  = 20;
    localparam int         MAXC = 3;
    localparam logic [7:0] TH   = 8'h10;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] audio_in = 8'h00;
    logic       clap_pulse;
    logic       cmd_valid;
    logic [1:0] cmd_claps;
    logic       light_on;
    logic       fan_on;
    logic       busy;

    clap_command_ctrl #(
        .SAMPLE_W    (8),
        .THRESHOLD   (TH),
        .HIT_SAMPLES (HITS),
        .LOCKOUT_CYC (LOCK),
        .WINDOW_CYC  (WIN),
        .MAX_CLAPS   (MAXC),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .sample_valid (sample_valid),
        .audio_in     (audio_in),
        .clap_pulse   (clap_pulse),
        .cmd_valid    (cmd_valid),
        .cmd_claps    (cmd_claps),
        .light_on     (light_on),
        .fan_on       (fan_on),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: elapsed time since the last clap plus a run of loud samples
    int t;
    bit armed;
    int claps;
    int run;
    bit rpt;
    int last_t;
    bit e_pulse, e_cmd, e_light, e_fan, e_busy;
    int e_claps;

    // Observation helpers for directed timing checks
    int npulse, ncmd, pulse_cyc, cmd_gap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        t = 0; armed = 0; claps = 0; run = 0; rpt = 0; last_t = 0;
        e_pulse = 0; e_cmd = 0; e_light = 0; e_fan = 0; e_busy = 0; e_claps = 0;
    endtask

    task automatic model_step(input bit en, input bit v, input logic [7:0] a);
        t++;
        e_pulse = 0;
        e_cmd   = 0;
        if (!en) begin
            armed = 0; claps = 0; run = 0; rpt = 0;
        end else if (!armed) begin
            armed = 1;
        end else if (rpt) begin
            e_cmd   = 1;
            e_claps = claps;
            if (claps == 2) e_light = !e_light;
            if (claps == 3) e_fan = !e_fan;
            claps = 0; run = 0; rpt = 0;
        end else if (claps > 0 && (t - last_t) >= WIN) begin
            rpt = 1; run = 0;
        end else if (claps > 0 && (t - last_t) <= LOCK) begin
            // lockout: sample ignored
        end else if (v) begin
            if (a > TH) begin
                run++;
                if (run == HITS) begin
                    run = 0; claps++; last_t = t; e_pulse = 1;
                    if (claps == MAXC) rpt = 1;
                end
            end else begin
                run = 0;
            end
        end
        e_busy = armed && (run > 0 || claps > 0 || rpt);
    endtask

    task automatic check_all();
        check("clap_pulse", 32'(clap_pulse), 32'(e_pulse));
        check("cmd_valid",  32'(cmd_valid),  32'(e_cmd));
        check("cmd_claps",  32'(cmd_claps),  32'(e_claps));
        check("light_on",   32'(light_on),   32'(e_light));
        check("fan_on",     32'(fan_on),     32'(e_fan));
        check("busy",       32'(busy),       32'(e_busy));
    endtask

    // One clock: drive inputs, advance the model on the edge, compare mid-cycle
    task automatic cycle(input bit en, input bit v, input logic [7:0] a);
        enable = en; sample_valid = v; audio_in = a;
        @(posedge clk);
        model_step(en, v, a);
        @(negedge clk);
        cyc++;
        if (clap_pulse) begin npulse++; pulse_cyc = cyc; end
        if (cmd_valid)  begin ncmd++; cmd_gap = cyc - pulse_cyc; end
        check_all();
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) cycle(1, 1, 8'h00);
    endtask

    task automatic clap();
        cycle(1, 1, 8'h40);
        cycle(1, 1, 8'h40);
        cycle(1, 1, 8'h00);
    endtask

    initial begin
        model_reset();
        npulse = 0; ncmd = 0; pulse_cyc = 0; cmd_gap = 0;
        #1;
        check("rst_clap_pulse", 32'(clap_pulse), 0);
        check("rst_cmd_valid",  32'(cmd_valid),  0);
        check("rst_cmd_claps",  32'(cmd_claps),  0);
        check("rst_light",      32'(light_on),   0);
        check("rst_fan",        32'(fan_on),     0);
        check("rst_busy",       32'(busy),       0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Single clap closes by window
        quiet(3);
        npulse = 0; ncmd = 0;
        clap();
        quiet(25);
        check("single_pulses", 32'(npulse), 1);
        check("single_cmds", 32'(ncmd), 1);
        check("single_latency", 32'(cmd_gap), WIN + 1);
        check("single_claps", 32'(cmd_claps), 1);
        check("single_light", 32'(light_on), 0);

        // Two claps 10 cycles apart, twice
        clap(); quiet(7); clap(); quiet(25);
        check("pair1_claps", 32'(cmd_claps), 2);
        check("pair1_light", 32'(light_on), 1);
        clap(); quiet(7); clap(); quiet(25);
        check("pair2_light", 32'(light_on), 0);

        // Three claps 8 cycles apart close immediately
        clap(); quiet(5); clap(); quiet(5); cycle(1, 1, 8'h40); cycle(1, 1, 8'h40);
        quiet(2);
        check("triple_latency", 32'(cmd_gap), 1);
        check("triple_claps", 32'(cmd_claps), 3);
        check("triple_fan", 32'(fan_on), 1);
        quiet(25);

        // Rejections
        npulse = 0;
        cycle(1, 1, 8'h40); cycle(1, 1, 8'h05); quiet(3);
        cycle(1, 1, 8'h10); cycle(1, 1, 8'h10); quiet(3);
        cycle(1, 0, 8'h40); cycle(1, 0, 8'h40); quiet(3);
        check("reject_pulses", 32'(npulse), 0);

        // Burst masked by lockout, then held past it
        npulse = 0;
        for (int i = 0; i < 5; i++) cycle(1, 1, 8'h80);
        quiet(25);
        check("burst5_pulses", 32'(npulse), 1);
        npulse = 0;
        for (int i = 0; i < 8; i++) cycle(1, 1, 8'h80);
        quiet(25);
        check("burst8_pulses", 32'(npulse), 2);

        // Asynchronous reset during GAP
        ncmd = 0;
        clap(); quiet(4);
        resetn = 1'b0;
        #1;
        model_reset();
        check("areset_busy", 32'(busy), 0);
        check("areset_fan", 32'(fan_on), 0);
        check("areset_claps", 32'(cmd_claps), 0);
        @(negedge clk);
        resetn = 1'b1;
        quiet(25);
        check("areset_nocmd", 32'(ncmd), 0);

        // Enable dropped during lockout keeps the light
        clap(); quiet(7); clap(); quiet(25);
        check("pre_abort_light", 32'(light_on), 1);
        ncmd = 0;
        cycle(1, 1, 8'h40); cycle(1, 1, 8'h40); cycle(1, 1, 8'h00);
        cycle(0, 1, 8'h00);
        check("abort_busy", 32'(busy), 0);
        check("abort_light", 32'(light_on), 1);
        quiet(25);
        check("abort_nocmd", 32'(ncmd), 0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit en, v;
            logic [7:0] a;
            en = ($urandom_range(0, 299) != 0);
            v  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) == 0) a = 8'($urandom_range(8'h11, 8'hFF));
            else                           a = 8'($urandom_range(0, 8'h10));
            cycle(en, v, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_clap_command_ctrl
`default_nettype wire
